// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M iterative multiplier.
package mul_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

  // Magnitude as an unsigned word, so -2^31 maps to 0x80000000.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-carry adder, purely combinational.
module fulladder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  always_comb begin : ripple
    logic c;
    c     = i_cin;
    o_sum = '0;
    for (int i = 0; i < 32; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/mul_unit.sv
// RV32M MUL/MULH/MULHSU/MULHU shift-add multiplier; result 33 cycles after accept
// (fewer with MUL_EARLY_EXIT_EN); busy until the result handshake, flush_i aborts.
module mul_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o
);

  import mul_pkg::*;

  state_e          r_state;
  state_e          w_state_nxt;
  mul_op_e         r_op;
  mul_op_e         w_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_mcand;
  logic            r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic [XLEN-1:0] w_add_a;
  logic [XLEN-1:0] w_add_b;
  logic            w_add_cin;
  logic [XLEN-1:0] w_sum;
  logic            w_cout;
  logic [XLEN-1:0] w_hi_step;
  logic [XLEN-1:0] w_lo_step;

  assign w_op       = mul_op_e'(op_i);
  assign w_accept   = req_valid_i & req_ready_o;
  assign w_a_signed = (w_op == MULH) || (w_op == MULHSU);
  assign w_b_signed = (w_op == MULH);

  // One adder: hi + (lo[0] ? mcand : 0) while iterating, ~hi + carry(~lo+1) when negating.
  always_comb begin
    w_add_a   = r_hi;
    w_add_b   = r_lo[0] ? r_mcand : '0;
    w_add_cin = 1'b0;
    if (r_state == SIGN) begin
      w_add_a   = ~r_hi;
      w_add_b   = '0;
      w_add_cin = (r_lo == '0);
    end
  end

  fulladder32 u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_hi_step = {w_cout, w_sum[XLEN-1:1]};
  assign w_lo_step = {w_sum[0], r_lo[XLEN-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  // Zero-detect of the not-yet-consumed multiplier bits is registered, so it
  // steers the iteration after the one that produced it.
  logic              r_rem_zero;
  logic [CNT_W:0]    w_cnt_p1;
  logic [CNT_W:0]    w_shamt;
  logic [XLEN-1:0]   w_rem_mask;
  logic [2*XLEN-1:0] w_skip;

  assign w_cnt_p1   = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_shamt    = (CNT_W+1)'(MUL_ITERS) - {1'b0, r_cnt};
  assign w_rem_mask = {XLEN{1'b1}} >> w_cnt_p1;
  assign w_skip     = {r_hi, r_lo} >> w_shamt;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = CALC;
      CALC: begin
        if (r_cnt == CNT_W'(MUL_ITERS - 1)) w_state_nxt = SIGN;
`ifdef MUL_EARLY_EXIT_EN
        if (r_rem_zero) w_state_nxt = SIGN;
`endif
      end
      SIGN: w_state_nxt = DONE;
      DONE: if (res_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  always_comb begin
    req_ready_o = (r_state == IDLE) && !flush_i;
    res_valid_o = (r_state == DONE);
    res_o       = '0;
    if (r_state == DONE) res_o = (r_op == MUL) ? r_lo : r_hi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op    <= MUL;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
`ifdef MUL_EARLY_EXIT_EN
      r_rem_zero <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op    <= w_op;
      r_hi    <= '0;
      r_lo    <= mag(b_i, w_b_signed);
      r_mcand <= mag(a_i, w_a_signed);
      r_neg   <= (w_a_signed & a_i[XLEN-1]) ^ (w_b_signed & b_i[XLEN-1]);
      r_cnt   <= '0;
`ifdef MUL_EARLY_EXIT_EN
      r_rem_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          if (r_rem_zero) begin
            r_hi <= w_skip[2*XLEN-1:XLEN];
            r_lo <= w_skip[XLEN-1:0];
          end else begin
            r_hi       <= w_hi_step;
            r_lo       <= w_lo_step;
            r_cnt      <= r_cnt + CNT_W'(1);
            r_rem_zero <= ((w_lo_step & w_rem_mask) == '0);
          end
`else
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + CNT_W'(1);
`endif
        end
        SIGN: begin
          if (r_neg) begin
            r_lo <= ~r_lo + XLEN'(1);
            r_hi <= w_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
